clk_period_meter: RTL and testbench

Measures an externally generated slow clock or periodic signal in units of the 100 MHz system clock. It reports the period and high time of each cycle, so divided clocks, sensor strobes or debug signals can be checked against their nominal frequency. It is the consuming end of the divided-clock path: it synchronises an asynchronous input, detects rising edges, counts system cycles between them, and flags loss of activity.

---
 rtl/clk_period_meter.sv | 54 +++++
 tb/tb_clk_period_meter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an asynchronous signal in system clock cycles
module clk_period_meter #(
  parameter int CNT_WIDTH = 27,
  parameter int TIMEOUT   = 100_000_000
) (
  input  logic                 clk100MHz,
  input  logic                 rst_n,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 timeout
);
  localparam logic [CNT_WIDTH-1:0] TO_MAX  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
  typedef enum logic {ARM, RUN} state_t;
  state_t state;
  logic s1, s2, s3, rise;
  logic [CNT_WIDTH-1:0] per_cnt, hi_cnt;
  assign rise = s2 & ~s3;
  always_ff @(posedge clk100MHz or negedge rst_n)
    if (!rst_n) begin
      {s1, s2, s3} <= 3'b000;
      state        <= ARM;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      period       <= '0;
      high_time    <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      {s1, s2, s3} <= {sig_in, s1, s2};
      if (rise) begin
        per_cnt <= '0;
        hi_cnt  <= CNT_WIDTH'(1);
        state   <= RUN;
        timeout <= 1'b0;
        valid   <= state == RUN;
        if (state == RUN) begin
          period    <= per_cnt + 1'b1;
          high_time <= hi_cnt;
        end
      end else if (per_cnt == TO_LAST) begin
        // counter parks here until the next edge re-arms the measurement
        timeout <= 1'b1;
        state   <= ARM;
        valid   <= 1'b0;
      end else begin
        per_cnt <= per_cnt + 1'b1;
        hi_cnt  <= (s2 && hi_cnt != TO_MAX) ? hi_cnt + 1'b1 : hi_cnt;
        valid   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of period/high-time measurement, timeout and reset
module tb_clk_period_meter;
  logic clk100MHz = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;
  logic [11:0] period, high_time;
  logic valid, timeout;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int to_seen = 0;
  int vq_c[$];
  int vq_p[$];
  int vq_h[$];

  clk_period_meter #(.CNT_WIDTH(12), .TIMEOUT(1000)) dut (
    .clk100MHz(clk100MHz),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .valid(valid),
    .timeout(timeout)
  );

  always #5 clk100MHz = ~clk100MHz;

  task automatic step(input logic v);
    sig_in = v;
    @(posedge clk100MHz);
    #1;
    cyc++;
    if (valid) begin
      vq_c.push_back(cyc);
      vq_p.push_back(int'(period));
      vq_h.push_back(int'(high_time));
    end
    if (timeout) to_seen++;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hi; j++) step(1'b1);
      for (int j = 0; j < lo; j++) step(1'b0);
    end
  endtask

  task automatic zeros(input int n);
    for (int j = 0; j < n; j++) step(1'b0);
  endtask

  task automatic clr();
    cyc = 0;
    to_seen = 0;
    vq_c.delete();
    vq_p.delete();
    vq_h.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held with the input toggling
    for (int i = 0; i < 6; i++) step(i[0]);
    chk("rst_period", 32'(period), 0);
    chk("rst_high", 32'(high_time), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    clr();
    zeros(999);
    chk("rel_to_early", 32'(timeout), 0);
    chk("rel_no_valid", vq_c.size(), 0);
    step(1'b0);
    chk("rel_to_1000", 32'(timeout), 1);

    // square 4/4: arm at edge 3, valids at 11,19,27,35
    clr();
    wave(4, 4, 5);
    chk("sq_nvalid", vq_c.size(), 4);
    chk("sq_first", vq_c[0], 11);
    chk("sq_spacing", vq_c[3] - vq_c[2], 8);
    for (int i = 0; i < 4; i++) begin
      chk("sq_period", vq_p[i], 8);
      chk("sq_high", vq_h[i], 4);
    end
    chk("sq_to_clear_edge", to_seen, 2);
    chk("sq_timeout", 32'(timeout), 0);

    // duty 3/7 then 2/2
    clr();
    wave(3, 7, 3);
    wave(2, 2, 3);
    chk("duty_nvalid", vq_c.size(), 6);
    chk("duty_first_p", vq_p[0], 8);
    chk("duty37_p", vq_p[1], 10);
    chk("duty37_h", vq_h[1], 3);
    chk("duty37_last_p", vq_p[3], 10);
    chk("duty37_last_h", vq_h[3], 3);
    chk("duty22_cyc", vq_c[4], 37);
    chk("duty22_p", vq_p[4], 4);
    chk("duty22_h", vq_h[4], 2);

    // rise spacing exactly 1000: rise wins over timeout
    clr();
    zeros(996);
    wave(2, 2, 1);
    chk("b1000_nvalid", vq_c.size(), 1);
    chk("b1000_cyc", vq_c[0], 999);
    chk("b1000_p", vq_p[0], 1000);
    chk("b1000_h", vq_h[0], 2);
    chk("b1000_no_to", to_seen, 0);

    // rise spacing 1001: timeout, re-arm, then a valid
    clr();
    zeros(997);
    step(1'b1);
    chk("b1001_to_pre", 32'(timeout), 0);
    step(1'b1);
    chk("b1001_to_set", 32'(timeout), 1);
    chk("b1001_hold_p", 32'(period), 1000);
    step(1'b0);
    chk("b1001_to_clr", 32'(timeout), 0);
    chk("b1001_no_valid", 32'(valid), 0);
    step(1'b0);
    wave(2, 2, 1);
    chk("b1001_nvalid", vq_c.size(), 1);
    chk("b1001_vcyc", vq_c[0], 1004);
    chk("b1001_p", vq_p[0], 4);
    chk("b1001_h", vq_h[0], 2);

    // stop toggling, timeout, then resume with period 6
    clr();
    zeros(998);
    chk("stop_to_pre", 32'(timeout), 0);
    step(1'b0);
    chk("stop_to_set", 32'(timeout), 1);
    chk("stop_hold_p", 32'(period), 4);
    chk("stop_hold_h", 32'(high_time), 2);
    wave(3, 3, 3);
    chk("resume_nvalid", vq_c.size(), 2);
    chk("resume_cyc", vq_c[0], 1008);
    chk("resume_p", vq_p[0], 6);
    chk("resume_h", vq_h[0], 3);
    chk("resume_to", 32'(timeout), 0);

    // reset 5 cycles after a rise
    clr();
    wave(3, 5, 1);
    chk("mid_pre_p", vq_p[0], 6);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_p", 32'(period), 0);
    chk("mid_rst_h", 32'(high_time), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_to", 32'(timeout), 0);
    zeros(2);
    rst_n = 1'b1;
    clr();
    wave(3, 3, 2);
    chk("post_nvalid", vq_c.size(), 1);
    chk("post_cyc", vq_c[0], 9);
    chk("post_p", vq_p[0], 6);
    chk("post_h", vq_h[0], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
